// File: rtl/pcie_tx_arb_multi.sv
// PCIe TX request arbiter: one CplD channel plus parametrised MRd/MWr channel sets,
// strict CplD priority, MRd/MWr alternation, per-class round robin and an NP read limit.
module pcie_tx_arb_multi #(
  parameter int C_PCIE_ADDR_WIDTH    = 48,
  parameter int C_NUM_MRD            = 3,
  parameter int C_NUM_MWR            = 2,
  parameter int C_MAX_NP_OUTSTANDING = 32,
  parameter int C_NP_CNT_WIDTH       = 6
) (
  input  logic                                          pcie_user_clk,
  input  logic                                          pcie_user_rst_n,
  input  logic                                          tx_cpld_gnt,
  input  logic                                          tx_mrd_gnt,
  input  logic                                          tx_mwr_gnt,
  input  logic                                          tx_cpld_req,
  input  logic [10:0]                                   tx_cpld_len,
  output logic                                          tx_cpld_req_ack,
  input  logic [C_NUM_MRD-1:0]                          tx_mrd_req,
  input  logic [8*C_NUM_MRD-1:0]                        tx_mrd_tag,
  input  logic [11*C_NUM_MRD-1:0]                       tx_mrd_len,
  input  logic [(C_PCIE_ADDR_WIDTH-2)*C_NUM_MRD-1:0]    tx_mrd_addr,
  output logic [C_NUM_MRD-1:0]                          tx_mrd_req_ack,
  input  logic [C_NUM_MWR-1:0]                          tx_mwr_req,
  input  logic [8*C_NUM_MWR-1:0]                        tx_mwr_tag,
  input  logic [11*C_NUM_MWR-1:0]                       tx_mwr_len,
  input  logic [(C_PCIE_ADDR_WIDTH-2)*C_NUM_MWR-1:0]    tx_mwr_addr,
  output logic [C_NUM_MWR-1:0]                          tx_mwr_req_ack,
  input  logic                                          np_cpl_done,
  output logic                                          tx_arb_valid,
  output logic [1:0]                                    tx_arb_type,
  output logic [2:0]                                    tx_arb_idx,
  output logic [10:0]                                   tx_arb_len,
  output logic [7:0]                                    tx_arb_tag,
  output logic [C_PCIE_ADDR_WIDTH-3:0]                  tx_arb_addr,
  input  logic                                          tx_arb_rdy,
  output logic [C_NP_CNT_WIDTH-1:0]                     np_outstanding
);

  localparam int AW = C_PCIE_ADDR_WIDTH - 2;
  localparam logic [1:0] TYPE_CPLD = 2'b00;
  localparam logic [1:0] TYPE_MRD  = 2'b01;
  localparam logic [1:0] TYPE_MWR  = 2'b10;

  typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} state_t;

  // Round-robin search starting one past ptr; returns {found, index}.
  // Iterating from the far end lets the nearest requester overwrite the result.
  function automatic logic [3:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr,
                                         input int n);
    logic [3:0] res;
    int c;
    res = 4'd0;
    for (int i = 8; i >= 1; i--) begin
      if (i <= n) begin
        c = int'(ptr) + i;
        if (c >= n) c = c - n;
        if (req[c[2:0]]) res = {1'b1, c[2:0]};
      end
    end
    return res;
  endfunction

  state_t                  state, state_nxt;
  logic                    last_mwr;
  logic [2:0]              mrd_ptr, mwr_ptr;
  logic [3:0]              mrd_pick, mwr_pick;
  logic                    np_room;
  logic                    cpld_elig, mrd_elig, mwr_elig;
  logic                    gnt_cpld, gnt_mrd, gnt_mwr, gnt_any;
  logic [C_NUM_MRD-1:0]    mrd_onehot;
  logic [C_NUM_MWR-1:0]    mwr_onehot;
  logic [1:0]              sel_type;
  logic [2:0]              sel_idx;
  logic [10:0]             sel_len;
  logic [7:0]              sel_tag;
  logic [AW-1:0]           sel_addr;
  logic                    cnt_inc, cnt_dec;

  // Grant decision (combinational, sampled only in IDLE)
  assign np_room   = np_outstanding < C_NP_CNT_WIDTH'(C_MAX_NP_OUTSTANDING);
  assign mrd_pick  = rr_pick(8'(tx_mrd_req), mrd_ptr, C_NUM_MRD);
  assign mwr_pick  = rr_pick(8'(tx_mwr_req), mwr_ptr, C_NUM_MWR);
  assign cpld_elig = tx_cpld_req & tx_cpld_gnt;
  assign mrd_elig  = mrd_pick[3] & tx_mrd_gnt & np_room;
  assign mwr_elig  = mwr_pick[3] & tx_mwr_gnt;
  assign gnt_any   = gnt_cpld | gnt_mrd | gnt_mwr;

  assign mrd_onehot = C_NUM_MRD'(1) << mrd_pick[2:0];
  assign mwr_onehot = C_NUM_MWR'(1) << mwr_pick[2:0];

  always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
    if (!pcie_user_rst_n) state <= S_IDLE;
    else                  state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    gnt_cpld  = 1'b0;
    gnt_mrd   = 1'b0;
    gnt_mwr   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (cpld_elig)                 gnt_cpld = 1'b1;
        else if (mrd_elig && mwr_elig) begin
          gnt_mrd = last_mwr;
          gnt_mwr = ~last_mwr;
        end
        else if (mrd_elig)             gnt_mrd = 1'b1;
        else if (mwr_elig)             gnt_mwr = 1'b1;
        if (cpld_elig || mrd_elig || mwr_elig) state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (tx_arb_valid && tx_arb_rdy) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    sel_type = TYPE_CPLD;
    sel_idx  = 3'd0;
    sel_len  = tx_cpld_len;
    sel_tag  = 8'd0;
    sel_addr = '0;
    if (gnt_mrd) begin
      sel_type = TYPE_MRD;
      sel_idx  = mrd_pick[2:0];
      sel_len  = tx_mrd_len[int'(mrd_pick[2:0])*11 +: 11];
      sel_tag  = tx_mrd_tag[int'(mrd_pick[2:0])*8 +: 8];
      sel_addr = tx_mrd_addr[int'(mrd_pick[2:0])*AW +: AW];
    end else if (gnt_mwr) begin
      sel_type = TYPE_MWR;
      sel_idx  = mwr_pick[2:0];
      sel_len  = tx_mwr_len[int'(mwr_pick[2:0])*11 +: 11];
      sel_tag  = tx_mwr_tag[int'(mwr_pick[2:0])*8 +: 8];
      sel_addr = tx_mwr_addr[int'(mwr_pick[2:0])*AW +: AW];
    end
  end

  // Registered grant: acks pulse for one cycle, fields hold until accepted
  always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
    if (!pcie_user_rst_n) begin
      tx_cpld_req_ack <= 1'b0;
      tx_mrd_req_ack  <= '0;
      tx_mwr_req_ack  <= '0;
      tx_arb_valid    <= 1'b0;
      tx_arb_type     <= 2'b00;
      tx_arb_idx      <= 3'd0;
      tx_arb_len      <= 11'd0;
      tx_arb_tag      <= 8'd0;
      tx_arb_addr     <= '0;
      mrd_ptr         <= 3'd0;
      mwr_ptr         <= 3'd0;
      last_mwr        <= 1'b1;
    end else begin
      tx_cpld_req_ack <= gnt_cpld;
      tx_mrd_req_ack  <= gnt_mrd ? mrd_onehot : '0;
      tx_mwr_req_ack  <= gnt_mwr ? mwr_onehot : '0;
      if (gnt_any) begin
        tx_arb_valid <= 1'b1;
        tx_arb_type  <= sel_type;
        tx_arb_idx   <= sel_idx;
        tx_arb_len   <= sel_len;
        tx_arb_tag   <= sel_tag;
        tx_arb_addr  <= sel_addr;
      end else if (state == S_HOLD && tx_arb_valid && tx_arb_rdy) begin
        tx_arb_valid <= 1'b0;
      end
      if (gnt_mrd) begin
        mrd_ptr  <= mrd_pick[2:0];
        last_mwr <= 1'b0;
      end
      if (gnt_mwr) begin
        mwr_ptr  <= mwr_pick[2:0];
        last_mwr <= 1'b1;
      end
    end
  end

  // Outstanding-read counter: the increment lands as the MRd ack cycle ends
  assign cnt_inc = |tx_mrd_req_ack;
  assign cnt_dec = np_cpl_done & (np_outstanding != '0);

  always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
    if (!pcie_user_rst_n) begin
      np_outstanding <= '0;
    end else if (cnt_inc && !cnt_dec && np_room) begin
      np_outstanding <= np_outstanding + C_NP_CNT_WIDTH'(1);
    end else if (cnt_dec && !cnt_inc) begin
      np_outstanding <= np_outstanding - C_NP_CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pcie_tx_arb_multi.sv
// Self-checking bench for pcie_tx_arb_multi: directed scenarios plus a randomized run
// compared against a transaction-level reference model.
module tb_pcie_tx_arb_multi;
  localparam int ADDRW = 48;
  localparam int NMRD  = 3;
  localparam int NMWR  = 2;
  localparam int MAXNP = 6;
  localparam int CNTW  = 6;
  localparam int AW    = ADDRW - 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_n = 1'b0;
  logic                  cpld_gnt, mrd_gnt, mwr_gnt;
  logic                  cpld_req;
  logic [10:0]           cpld_len;
  logic                  cpld_ack;
  logic [NMRD-1:0]       mrd_req, mrd_ack;
  logic [8*NMRD-1:0]     mrd_tag;
  logic [11*NMRD-1:0]    mrd_len;
  logic [AW*NMRD-1:0]    mrd_addr;
  logic [NMWR-1:0]       mwr_req, mwr_ack;
  logic [8*NMWR-1:0]     mwr_tag;
  logic [11*NMWR-1:0]    mwr_len;
  logic [AW*NMWR-1:0]    mwr_addr;
  logic                  np_done;
  logic                  a_valid;
  logic [1:0]            a_type;
  logic [2:0]            a_idx;
  logic [10:0]           a_len;
  logic [7:0]            a_tag;
  logic [AW-1:0]         a_addr;
  logic                  a_rdy;
  logic [CNTW-1:0]       np_out;
  logic [5:0]            acks;

  assign acks = {cpld_ack, mrd_ack, mwr_ack};

  int checks = 0;
  int failures = 0;

  pcie_tx_arb_multi #(
    .C_PCIE_ADDR_WIDTH(ADDRW), .C_NUM_MRD(NMRD), .C_NUM_MWR(NMWR),
    .C_MAX_NP_OUTSTANDING(MAXNP), .C_NP_CNT_WIDTH(CNTW)
  ) dut (
    .pcie_user_clk(clk), .pcie_user_rst_n(rst_n),
    .tx_cpld_gnt(cpld_gnt), .tx_mrd_gnt(mrd_gnt), .tx_mwr_gnt(mwr_gnt),
    .tx_cpld_req(cpld_req), .tx_cpld_len(cpld_len), .tx_cpld_req_ack(cpld_ack),
    .tx_mrd_req(mrd_req), .tx_mrd_tag(mrd_tag), .tx_mrd_len(mrd_len),
    .tx_mrd_addr(mrd_addr), .tx_mrd_req_ack(mrd_ack),
    .tx_mwr_req(mwr_req), .tx_mwr_tag(mwr_tag), .tx_mwr_len(mwr_len),
    .tx_mwr_addr(mwr_addr), .tx_mwr_req_ack(mwr_ack),
    .np_cpl_done(np_done),
    .tx_arb_valid(a_valid), .tx_arb_type(a_type), .tx_arb_idx(a_idx),
    .tx_arb_len(a_len), .tx_arb_tag(a_tag), .tx_arb_addr(a_addr),
    .tx_arb_rdy(a_rdy), .np_outstanding(np_out)
  );

  // Reference model: one granted transaction at a time, tracked as plain variables.
  int              m_cnt, m_ptr_mrd, m_ptr_mwr, m_type, m_idx;
  bit              m_last_mwr, m_valid, m_ack_cpld;
  logic [NMRD-1:0] m_ack_mrd;
  logic [NMWR-1:0] m_ack_mwr;
  logic [10:0]     m_len;
  logic [7:0]      m_tag;
  logic [AW-1:0]   m_addr;

  function automatic int rr_next(int ptr, int n, logic [7:0] req);
    int c;
    for (int k = 1; k <= n; k++) begin
      c = (ptr + k) % n;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    m_cnt = 0; m_ptr_mrd = 0; m_ptr_mwr = 0; m_type = 0; m_idx = 0;
    m_last_mwr = 1'b1; m_valid = 1'b0; m_ack_cpld = 1'b0;
    m_ack_mrd = '0; m_ack_mwr = '0; m_len = '0; m_tag = '0; m_addr = '0;
  endfunction

  function automatic void model_step();
    bit inc, dec, e_c, e_r, e_w;
    int cls, pick;
    inc = (m_ack_mrd != '0);
    dec = np_done && (m_cnt > 0);
    m_ack_cpld = 1'b0; m_ack_mrd = '0; m_ack_mwr = '0;
    if (m_valid) begin
      if (a_rdy) m_valid = 1'b0;
    end else begin
      e_c = cpld_req && cpld_gnt;
      e_r = (mrd_req != '0) && mrd_gnt && (m_cnt < MAXNP);
      e_w = (mwr_req != '0) && mwr_gnt;
      cls = 0;
      if (e_c) cls = 1;
      else if (e_r && e_w) cls = m_last_mwr ? 2 : 3;
      else if (e_r) cls = 2;
      else if (e_w) cls = 3;
      if (cls == 1) begin
        m_valid = 1'b1; m_type = 0; m_idx = 0; m_len = cpld_len; m_tag = '0; m_addr = '0;
        m_ack_cpld = 1'b1;
      end else if (cls == 2) begin
        pick = rr_next(m_ptr_mrd, NMRD, 8'(mrd_req));
        m_ptr_mrd = pick; m_last_mwr = 1'b0;
        m_valid = 1'b1; m_type = 1; m_idx = pick;
        m_len = mrd_len[11*pick +: 11]; m_tag = mrd_tag[8*pick +: 8];
        m_addr = mrd_addr[AW*pick +: AW]; m_ack_mrd[pick] = 1'b1;
      end else if (cls == 3) begin
        pick = rr_next(m_ptr_mwr, NMWR, 8'(mwr_req));
        m_ptr_mwr = pick; m_last_mwr = 1'b1;
        m_valid = 1'b1; m_type = 2; m_idx = pick;
        m_len = mwr_len[11*pick +: 11]; m_tag = mwr_tag[8*pick +: 8];
        m_addr = mwr_addr[AW*pick +: AW]; m_ack_mwr[pick] = 1'b1;
      end
    end
    if (inc && !dec) m_cnt++;
    else if (dec && !inc) m_cnt--;
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cpld_gnt = 1'b1; mrd_gnt = 1'b1; mwr_gnt = 1'b1;
    cpld_req = 1'b0; cpld_len = '0;
    mrd_req = '0; mrd_tag = '0; mrd_len = '0; mrd_addr = '0;
    mwr_req = '0; mwr_tag = '0; mwr_len = '0; mwr_addr = '0;
    np_done = 1'b0; a_rdy = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc();
      checks++;
      if ({a_valid, acks, a_type, a_idx, a_len, a_tag, a_addr, np_out} !== '0) begin
        failures++;
        $display("FAIL reset cyc=%0d: valid=%b acks=%b type=%0d len=%h np=%0d, want all 0",
                 i, a_valid, acks, a_type, a_len, np_out);
      end
    end
  endtask

  task automatic test_priority();
    do_reset();
    cpld_req = 1'b1; cpld_len = 11'h123;
    mrd_req = 3'b001; mrd_tag[7:0] = 8'h5A; mrd_len[10:0] = 11'h040;
    mrd_addr[AW-1:0] = AW'(46'h0ABC_DEF0_1234);
    mwr_req = 2'b01; mwr_tag[7:0] = 8'hC3; mwr_len[10:0] = 11'h7FF;
    mwr_addr[AW-1:0] = {AW{1'b1}};
    cyc(); checks++;
    if (acks !== 6'b100000 || a_valid !== 1'b1 || a_type !== 2'b00 || a_len !== 11'h123 ||
        a_tag !== 8'h00 || a_addr !== '0) begin
      failures++;
      $display("FAIL prio_cpld: acks=%b valid=%b type=%0d len=%h, want 100000/1/0/123",
               acks, a_valid, a_type, a_len);
    end
    cpld_req = 1'b0;
    cyc(); checks++;
    if (acks !== 6'b0 || a_valid !== 1'b0) begin
      failures++; $display("FAIL prio_gap1: acks=%b valid=%b, want 0/0", acks, a_valid);
    end
    cyc(); checks++;
    if (acks !== 6'b000100 || a_type !== 2'b01 || a_idx !== 3'd0 || a_tag !== 8'h5A ||
        a_len !== 11'h040 || a_addr !== AW'(46'h0ABC_DEF0_1234) || np_out !== 6'd0) begin
      failures++;
      $display("FAIL prio_mrd: acks=%b type=%0d idx=%0d tag=%h len=%h np=%0d, want 000100/1/0/5a/040/0",
               acks, a_type, a_idx, a_tag, a_len, np_out);
    end
    mrd_req = '0;
    cyc(); checks++;
    if (acks !== 6'b0 || a_valid !== 1'b0 || np_out !== 6'd1) begin
      failures++;
      $display("FAIL prio_gap2: acks=%b valid=%b np=%0d, want 0/0/1", acks, a_valid, np_out);
    end
    cyc(); checks++;
    if (acks !== 6'b000001 || a_type !== 2'b10 || a_idx !== 3'd0 || a_tag !== 8'hC3 ||
        a_len !== 11'h7FF || a_addr !== {AW{1'b1}}) begin
      failures++;
      $display("FAIL prio_mwr: acks=%b type=%0d idx=%0d tag=%h len=%h, want 000001/2/0/c3/7ff",
               acks, a_type, a_idx, a_tag, a_len);
    end
    mwr_req = '0;
    cyc(); checks++;
    if (acks !== 6'b0 || a_valid !== 1'b0) begin
      failures++; $display("FAIL prio_gap3: acks=%b valid=%b, want 0/0", acks, a_valid);
    end
  endtask

  task automatic test_round_robin();
    int exp;
    do_reset();
    for (int i = 0; i < NMRD; i++) begin
      mrd_tag[8*i +: 8] = 8'(16 + i);
      mrd_len[11*i +: 11] = 11'(i + 1);
      mrd_addr[AW*i +: AW] = AW'(64 * i + 4);
    end
    mrd_req = 3'b111;
    for (int g = 0; g < 6; g++) begin
      exp = (g + 1) % NMRD;
      cyc(); checks++;
      if (acks !== (6'd1 << (2 + exp)) || a_type !== 2'b01 || a_idx !== 3'(exp) ||
          a_tag !== 8'(16 + exp) || a_addr !== AW'(64 * exp + 4)) begin
        failures++;
        $display("FAIL rr_grant%0d: acks=%b idx=%0d tag=%h, want idx=%0d", g, acks, a_idx,
                 a_tag, exp);
      end
      cyc(); checks++;
      if (acks !== 6'b0 || a_valid !== 1'b0 || np_out !== CNTW'(g + 1)) begin
        failures++;
        $display("FAIL rr_count%0d: acks=%b valid=%b np=%0d, want np=%0d", g, acks, a_valid,
                 np_out, g + 1);
      end
    end
  endtask

  // Continues from test_round_robin: counter sits at the limit with all MRd channels requesting.
  task automatic test_np_limit();
    for (int i = 0; i < 4; i++) begin
      cyc(); checks++;
      if (acks !== 6'b0 || a_valid !== 1'b0 || np_out !== CNTW'(MAXNP)) begin
        failures++;
        $display("FAIL limit_hold%0d: acks=%b valid=%b np=%0d, want 0/0/%0d", i, acks, a_valid,
                 np_out, MAXNP);
      end
    end
    mwr_req = 2'b01; mwr_tag[7:0] = 8'h77;
    cyc(); checks++;
    if (acks !== 6'b000001 || a_type !== 2'b10 || a_tag !== 8'h77) begin
      failures++; $display("FAIL limit_mwr: acks=%b type=%0d, want 000001/2", acks, a_type);
    end
    mwr_req = '0;
    cyc();
    cpld_req = 1'b1; cpld_len = 11'h001;
    cyc(); checks++;
    if (acks !== 6'b100000 || a_type !== 2'b00 || a_len !== 11'h001) begin
      failures++; $display("FAIL limit_cpld: acks=%b type=%0d, want 100000/0", acks, a_type);
    end
    cpld_req = 1'b0;
    cyc();
    np_done = 1'b1;
    cyc(); checks++;
    np_done = 1'b0;
    if (acks !== 6'b0 || np_out !== CNTW'(MAXNP - 1)) begin
      failures++;
      $display("FAIL limit_dec: acks=%b np=%0d, want 0/%0d", acks, np_out, MAXNP - 1);
    end
    cyc(); checks++;
    if (acks !== 6'b001000 || a_idx !== 3'd1) begin
      failures++; $display("FAIL limit_regrant: acks=%b idx=%0d, want 001000/1", acks, a_idx);
    end
    cyc(); checks++;
    if (np_out !== CNTW'(MAXNP) || a_valid !== 1'b0) begin
      failures++;
      $display("FAIL limit_refill: np=%0d valid=%b, want %0d/0", np_out, a_valid, MAXNP);
    end
  endtask

  task automatic test_hold();
    mrd_req = '0;
    mwr_tag[15:8] = 8'hE7; mwr_len[21:11] = 11'h00A;
    mwr_addr[2*AW-1:AW] = AW'(46'h1234_5678_9AB);
    mwr_req = 2'b10; a_rdy = 1'b0;
    cyc(); checks++;
    if (acks !== 6'b000010 || a_valid !== 1'b1 || a_type !== 2'b10 || a_idx !== 3'd1) begin
      failures++;
      $display("FAIL hold_grant: acks=%b valid=%b type=%0d idx=%0d, want 000010/1/2/1",
               acks, a_valid, a_type, a_idx);
    end
    mwr_req = '0; mwr_gnt = 1'b0; cpld_req = 1'b1; cpld_len = 11'h005;
    for (int i = 0; i < 5; i++) begin
      cyc(); checks++;
      if (acks !== 6'b0 || a_valid !== 1'b1 || a_type !== 2'b10 || a_idx !== 3'd1 ||
          a_len !== 11'h00A || a_tag !== 8'hE7 || a_addr !== AW'(46'h1234_5678_9AB)) begin
        failures++;
        $display("FAIL hold_stable%0d: acks=%b valid=%b type=%0d idx=%0d len=%h tag=%h",
                 i, acks, a_valid, a_type, a_idx, a_len, a_tag);
      end
    end
    a_rdy = 1'b1;
    cyc(); checks++;
    if (a_valid !== 1'b0 || acks !== 6'b0) begin
      failures++; $display("FAIL hold_release: valid=%b acks=%b, want 0/0", a_valid, acks);
    end
    cyc(); checks++;
    if (acks !== 6'b100000 || a_len !== 11'h005) begin
      failures++; $display("FAIL hold_next_cpld: acks=%b len=%h, want 100000/005", acks, a_len);
    end
    cpld_req = 1'b0; mwr_gnt = 1'b1;
    cyc();
  endtask

  task automatic test_counter_edges();
    do_reset();
    mrd_req = 3'b001; mrd_tag[7:0] = 8'h01;
    for (int g = 0; g < 4; g++) begin
      cyc(); cyc(); checks++;
      if (np_out !== CNTW'(g + 1)) begin
        failures++; $display("FAIL cnt_fill%0d: np=%0d, want %0d", g, np_out, g + 1);
      end
    end
    cyc(); checks++;
    if (acks !== 6'b000100 || np_out !== 6'd4) begin
      failures++; $display("FAIL cnt_ack5: acks=%b np=%0d, want 000100/4", acks, np_out);
    end
    np_done = 1'b1; mrd_req = '0;
    cyc(); np_done = 1'b0; checks++;
    if (np_out !== 6'd4) begin
      failures++; $display("FAIL cnt_coincide: np=%0d, want 4", np_out);
    end
    for (int k = 3; k >= 0; k--) begin
      np_done = 1'b1;
      cyc(); np_done = 1'b0; checks++;
      if (np_out !== CNTW'(k)) begin
        failures++; $display("FAIL cnt_drain%0d: np=%0d, want %0d", k, np_out, k);
      end
    end
    np_done = 1'b1;
    cyc(); np_done = 1'b0; checks++;
    if (np_out !== 6'd0) begin
      failures++; $display("FAIL cnt_underflow: np=%0d, want 0", np_out);
    end
  endtask

  task automatic test_reset_in_hold();
    do_reset();
    mrd_req = 3'b001; a_rdy = 1'b0;
    cyc(); cyc(); checks++;
    if (a_valid !== 1'b1 || np_out !== 6'd1) begin
      failures++; $display("FAIL rsthold_pre: valid=%b np=%0d, want 1/1", a_valid, np_out);
    end
    rst_n = 1'b0;
    #1; checks++;
    if (a_valid !== 1'b0 || np_out !== 6'd0 || acks !== 6'b0) begin
      failures++;
      $display("FAIL rsthold_async: valid=%b np=%0d acks=%b, want 0/0/0", a_valid, np_out, acks);
    end
    do_reset();
    mrd_req = 3'b001;
    cyc(); checks++;
    if (acks !== 6'b000100 || a_valid !== 1'b1) begin
      failures++; $display("FAIL rsthold_rereq: acks=%b valid=%b, want 000100/1", acks, a_valid);
    end
    mrd_req = '0;
    cyc();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < NMRD; i++) begin
        if (m_ack_mrd[i] || (!mrd_req[i] && $urandom_range(0, 3) == 0)) begin
          mrd_req[i] = m_ack_mrd[i] ? 1'($urandom_range(0, 1)) : 1'b1;
          mrd_tag[8*i +: 8] = 8'($urandom);
          mrd_len[11*i +: 11] = 11'($urandom);
          mrd_addr[AW*i +: AW] = AW'({$urandom(), $urandom()});
        end
      end
      for (int i = 0; i < NMWR; i++) begin
        if (m_ack_mwr[i] || (!mwr_req[i] && $urandom_range(0, 3) == 0)) begin
          mwr_req[i] = m_ack_mwr[i] ? 1'($urandom_range(0, 1)) : 1'b1;
          mwr_tag[8*i +: 8] = 8'($urandom);
          mwr_len[11*i +: 11] = 11'($urandom);
          mwr_addr[AW*i +: AW] = AW'({$urandom(), $urandom()});
        end
      end
      if (m_ack_cpld || (!cpld_req && $urandom_range(0, 5) == 0)) begin
        cpld_req = m_ack_cpld ? 1'b0 : 1'b1;
        cpld_len = 11'($urandom);
      end
      cpld_gnt = ($urandom_range(0, 9) != 0);
      mrd_gnt  = ($urandom_range(0, 9) != 0);
      mwr_gnt  = ($urandom_range(0, 9) != 0);
      a_rdy    = ($urandom_range(0, 3) != 0);
      np_done  = ($urandom_range(0, 4) == 0);
      cyc();
      checks++;
      if (a_valid !== m_valid || acks !== {m_ack_cpld, m_ack_mrd, m_ack_mwr} ||
          np_out !== CNTW'(m_cnt)) begin
        failures++;
        $display("FAIL rand_ctrl n=%0d: valid=%b acks=%b np=%0d, want %b/%b/%0d", n, a_valid,
                 acks, np_out, m_valid, {m_ack_cpld, m_ack_mrd, m_ack_mwr}, m_cnt);
      end
      if (m_valid) begin
        checks++;
        if (a_type !== 2'(m_type) || a_idx !== 3'(m_idx) || a_len !== m_len ||
            a_tag !== m_tag || a_addr !== m_addr) begin
          failures++;
          $display("FAIL rand_fields n=%0d: type=%0d idx=%0d len=%h tag=%h, want %0d/%0d/%h/%h",
                   n, a_type, a_idx, a_len, a_tag, m_type, m_idx, m_len, m_tag);
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_priority();
    test_round_robin();
    test_np_limit();
    test_hold();
    test_counter_edges();
    test_reset_in_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
